// File: rtl/control_fsm.sv
// -----------------------------------------------------------------------------
// control_fsm
//   Multi-cycle control unit for the 16-bit CPU.
//   - Accepts one instruction per valid/ready handshake.
//   - Sequences FETCH -> DECODE -> EXEC -> {WB | MEM | BR} -> FETCH.
//   - Drives the ALU opcode and operand select, the register-file addresses
//     and write enable, the memory request and the PC control pulses.
//   Instruction format: [15:12] op, [11:8] rd, [7:4] rs, [3:0] rt/imm4.
//
// Ports
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   instr, instr_valid  instruction word and its valid flag
//   instr_ready         high only in FETCH
//   alu_op              ALU opcode (= IR[15:12])
//   alu_zero            ALU zero flag, used by beq
//   alu_src_imm, imm    ALU B-operand select and extended imm4
//   rf_ra, rf_rb, rf_wa register-file read/write addresses
//   rf_we               register write enable (one-cycle pulse in WB)
//   wb_sel_mem          writeback source: 1 = memory data (ldr), 0 = ALU
//   mem_req, mem_we     memory request (held until mem_ack) and store flag
//   mem_ack             memory completion
//   pc_inc, pc_branch   PC control pulses, never both high
//   trap                sticky fault: illegal opcode or memory timeout
// -----------------------------------------------------------------------------
module control_fsm #(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] instr,
  input  logic        instr_valid,
  output logic        instr_ready,
  output logic [3:0]  alu_op,
  input  logic        alu_zero,
  output logic        alu_src_imm,
  output logic [15:0] imm,
  output logic [3:0]  rf_ra,
  output logic [3:0]  rf_rb,
  output logic [3:0]  rf_wa,
  output logic        rf_we,
  output logic        wb_sel_mem,
  output logic        mem_req,
  output logic        mem_we,
  input  logic        mem_ack,
  output logic        pc_inc,
  output logic        pc_branch,
  output logic        trap
);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_ADDI = 4'd1;
  localparam logic [3:0] OP_SUB  = 4'd2;
  localparam logic [3:0] OP_AND  = 4'd3;
  localparam logic [3:0] OP_OR   = 4'd4;
  localparam logic [3:0] OP_XOR  = 4'd5;
  localparam logic [3:0] OP_NOT  = 4'd6;
  localparam logic [3:0] OP_SLT  = 4'd7;
  localparam logic [3:0] OP_LSL  = 4'd8;
  localparam logic [3:0] OP_LSR  = 4'd9;
  localparam logic [3:0] OP_LDR  = 4'd10;
  localparam logic [3:0] OP_STR  = 4'd11;
  localparam logic [3:0] OP_BEQ  = 4'd12;

  // Value of the wait counter on the last MEM cycle before a timeout.
  localparam logic [7:0] TIMEOUT_LAST = 8'(MEM_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_BR     = 3'd5,
    S_TRAP   = 3'd6
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] ir_q, ir_d;
  logic [7:0]  cnt_q, cnt_d;

  logic [3:0] op, rd, rs, rt;
  logic       is_ldr, is_str, is_beq, is_illegal;

  assign op = ir_q[15:12];
  assign rd = ir_q[11:8];
  assign rs = ir_q[7:4];
  assign rt = ir_q[3:0];

  assign is_ldr     = (op == OP_LDR);
  assign is_str     = (op == OP_STR);
  assign is_beq     = (op == OP_BEQ);
  assign is_illegal = (op > OP_BEQ);

  // ---------------------------------------------------------------------------
  // Operand decode: purely combinational from IR, so it stays stable for the
  // whole time the instruction is in flight.
  // ---------------------------------------------------------------------------
  always_comb begin
    alu_op      = op;
    rf_wa       = rd;
    rf_ra       = rs;
    rf_rb       = rt;
    alu_src_imm = 1'b0;
    imm         = {{12{rt[3]}}, rt};
    wb_sel_mem  = is_ldr;
    case (op)
      OP_ADDI: alu_src_imm = 1'b1;
      OP_LSL, OP_LSR: begin
        alu_src_imm = 1'b1;
        imm         = {12'd0, rt};   // shift amounts are unsigned
      end
      OP_LDR, OP_STR: begin
        alu_src_imm = 1'b1;          // address = rs + sext(imm4)
        rf_rb       = rd;            // store data comes from rd
      end
      OP_BEQ: begin
        rf_ra = rd;                  // compare rd against rs
        rf_rb = rs;
      end
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOT, OP_SLT: ;
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State, instruction and wait-counter registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      ir_q    <= 16'd0;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      cnt_q   <= cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and control outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    ir_d        = ir_q;
    cnt_d       = cnt_q;
    instr_ready = 1'b0;
    rf_we       = 1'b0;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    pc_inc      = 1'b0;
    pc_branch   = 1'b0;
    trap        = 1'b0;

    case (state_q)
      S_FETCH: begin
        instr_ready = 1'b1;
        if (instr_valid) begin
          ir_d    = instr;
          state_d = S_DECODE;
        end
      end

      S_DECODE: begin
        state_d = is_illegal ? S_TRAP : S_EXEC;
      end

      S_EXEC: begin
        if (is_ldr || is_str) state_d = S_MEM;
        else if (is_beq)      state_d = S_BR;
        else                  state_d = S_WB;
      end

      S_MEM: begin
        mem_req = 1'b1;
        mem_we  = is_str;
        if (mem_ack) begin
          // An ack on the last counted cycle still completes the access.
          cnt_d = 8'd0;
          if (is_str) begin
            pc_inc  = 1'b1;          // stores have no writeback stage
            state_d = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end else if (cnt_q == TIMEOUT_LAST) begin
          cnt_d   = 8'd0;
          state_d = S_TRAP;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      S_WB: begin
        rf_we   = 1'b1;
        pc_inc  = 1'b1;
        state_d = S_FETCH;
      end

      S_BR: begin
        if (alu_zero) pc_branch = 1'b1;
        else          pc_inc    = 1'b1;
        state_d = S_FETCH;
      end

      S_TRAP: begin
        trap = 1'b1;                 // only reset leaves this state
      end

      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

endmodule
